mem_ctrl: RTL and testbench

Memory controller that arbitrates the single byte-wide RAM/IO port between instruction fetch (the PC/IF path) and the MEM stage (loads/stores). It serialises each 1/2/4-byte request into byte accesses, assembles little-endian read data, and returns a one-cycle done pulse to the winning requester. It sits between the pipeline front/back ends and the top-level `mem_a`/`mem_dout`/`mem_wr`/`mem_din` pins.

---
 rtl/mem_ctrl_if.sv | 38 +++
 rtl/mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Request/done handshakes for the fetch and MEM paths plus the byte-wide RAM/IO port.
// The controller uses the slave modport; the pipeline/RAM side uses master.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              rdy_in;
  logic              if_req_in;
  logic [ADDR_W-1:0] if_addr_in;
  logic              if_done_out;
  logic [31:0]       if_data_out;
  logic              mem_req_in;
  logic              mem_we_in;
  logic [1:0]        mem_len_in;
  logic [ADDR_W-1:0] mem_addr_in;
  logic [31:0]       mem_wdata_in;
  logic              mem_done_out;
  logic [31:0]       mem_rdata_out;
  logic              io_buffer_full_in;
  logic [ADDR_W-1:0] ram_a_out;
  logic [7:0]        ram_dout_out;
  logic              ram_wr_out;
  logic [7:0]        ram_din_in;
  logic              busy_out;

  modport slave (
    input  rdy_in, if_req_in, if_addr_in, mem_req_in, mem_we_in, mem_len_in,
           mem_addr_in, mem_wdata_in, io_buffer_full_in, ram_din_in,
    output if_done_out, if_data_out, mem_done_out, mem_rdata_out,
           ram_a_out, ram_dout_out, ram_wr_out, busy_out
  );

  modport master (
    output rdy_in, if_req_in, if_addr_in, mem_req_in, mem_we_in, mem_len_in,
           mem_addr_in, mem_wdata_in, io_buffer_full_in, ram_din_in,
    input  if_done_out, if_data_out, mem_done_out, mem_rdata_out,
           ram_a_out, ram_dout_out, ram_wr_out, busy_out
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide RAM/IO port between instruction fetch and the MEM stage,
// serialising 1/2/4-byte requests into byte accesses with little-endian assembly.
module mem_ctrl #(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(32'h0003_0000)
) (
  input logic       clk_in,
  input logic       rst_in,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [2:0]        nbytes;
  logic              owner_mem;
  logic              we_q;
  logic              wr_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic [7:0]        dout_q;
  logic              if_done_q;
  logic              mem_done_q;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_rdata_q;

  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf_q;

  logic              mem_io_blocked;
  logic              mem_ok;
  logic              if_ok;
  logic              grant_mem;
  logic              grant_if;
  logic [2:0]        cnt_nxt;
  logic [1:0]        rd_idx;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       rbuf_nxt;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction

  // The just-finished owner may still hold its request during DONE, so it is masked there.
  always_comb begin
    mem_io_blocked = bus.mem_we_in && bus.io_buffer_full_in && (bus.mem_addr_in == IO_ADDR);
    mem_ok    = bus.mem_req_in && !mem_io_blocked && !((state == S_DONE) && owner_mem);
    if_ok     = bus.if_req_in && !((state == S_DONE) && !owner_mem);
    grant_mem = mem_ok && (state != S_XFER);
    grant_if  = if_ok && !mem_ok && (state != S_XFER);
    cnt_nxt   = cnt + 3'd1;
    addr_nxt  = base_q + ADDR_W'(cnt_nxt);
    rd_idx    = cnt[1:0] - 2'd1;
    rbuf_nxt  = rbuf_q;
    rbuf_nxt[{rd_idx, 3'b000} +: 8] = bus.ram_din_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= S_IDLE;
      cnt         <= '0;
      nbytes      <= '0;
      owner_mem   <= 1'b0;
      we_q        <= 1'b0;
      wr_q        <= 1'b0;
      ram_a_q     <= '0;
      dout_q      <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else if (bus.rdy_in) begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          wr_q  <= 1'b0;
          if (grant_mem) begin
            state     <= S_XFER;
            cnt       <= '0;
            owner_mem <= 1'b1;
            nbytes    <= len_bytes(bus.mem_len_in);
            we_q      <= bus.mem_we_in;
            wr_q      <= bus.mem_we_in;
            ram_a_q   <= bus.mem_addr_in;
            dout_q    <= bus.mem_wdata_in[7:0];
          end else if (grant_if) begin
            state     <= S_XFER;
            cnt       <= '0;
            owner_mem <= 1'b0;
            nbytes    <= 3'd4;
            we_q      <= 1'b0;
            ram_a_q   <= bus.if_addr_in;
          end
        end
        S_XFER: begin
          if (we_q) begin
            if (cnt == nbytes - 3'd1) begin
              state      <= S_DONE;
              wr_q       <= 1'b0;
              mem_done_q <= 1'b1;
            end else begin
              cnt     <= cnt_nxt;
              ram_a_q <= addr_nxt;
              dout_q  <= pick_byte(wdata_q, cnt_nxt[1:0]);
            end
          end else if (cnt == nbytes) begin
            // Last byte arrives on this edge; publish the assembled word directly.
            state <= S_DONE;
            if (owner_mem) begin
              mem_done_q  <= 1'b1;
              mem_rdata_q <= rbuf_nxt;
            end else begin
              if_done_q <= 1'b1;
              if_data_q <= rbuf_nxt;
            end
          end else begin
            cnt     <= cnt_nxt;
            ram_a_q <= addr_nxt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (bus.rdy_in) begin
      if ((state != S_XFER) && (grant_mem || grant_if)) begin
        base_q  <= grant_mem ? bus.mem_addr_in : bus.if_addr_in;
        wdata_q <= grant_mem ? bus.mem_wdata_in : '0;
        rbuf_q  <= '0;
      end else if ((state == S_XFER) && !we_q && (cnt != 3'd0)) begin
        rbuf_q <= rbuf_nxt;
      end
    end
  end

  assign bus.ram_a_out     = ram_a_q;
  assign bus.ram_dout_out  = dout_q;
  assign bus.ram_wr_out    = wr_q & bus.rdy_in;
  assign bus.if_done_out   = if_done_q;
  assign bus.if_data_out   = if_data_q;
  assign bus.mem_done_out  = mem_done_q;
  assign bus.mem_rdata_out = mem_rdata_q;
  assign bus.busy_out      = (state != S_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, done/write scoreboards, vector table and
// hand-written sequences for arbitration, IO back-pressure, stalls and reset.
module tb_mem_ctrl;

  localparam logic [31:0] IO_A = 32'h0003_0000;

  typedef struct {
    logic        is_mem;
    logic        chk_data;
    logic [31:0] data;
    int          cyc;
    string       tag;
  } sb_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          lat;
    string       tag;
  } vec_t;

  logic clk_in;
  logic rst_in;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  sb_t  sb[$];
  wr_t  wq[$];
  logic [7:0] ram [0:8191];
  vec_t vecs [10];

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .IO_ADDR(IO_A)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Byte RAM: read data appears the cycle after the address, frozen while rdy_in is low.
  always @(posedge clk_in) begin
    if (!rst_in) begin
      ram[13'h0004] <= 8'h13; ram[13'h0005] <= 8'h05;
      ram[13'h0006] <= 8'h00; ram[13'h0007] <= 8'h00;
      ram[13'h1000] <= 8'h78; ram[13'h1001] <= 8'h56;
      ram[13'h1002] <= 8'h34; ram[13'h1003] <= 8'h12;
      ram[13'h1FFF] <= 8'h5A; ram[13'h0000] <= 8'h01;
      ram[13'h0001] <= 8'h02; ram[13'h0002] <= 8'h03;
    end else if (bus.rdy_in) begin
      if (bus.ram_wr_out && (bus.ram_a_out != IO_A))
        ram[bus.ram_a_out[12:0]] <= bus.ram_dout_out;
      bus.ram_din_in <= ram[bus.ram_a_out[12:0]];
    end
  end

  always @(negedge clk_in) begin
    if (rst_in && (bus.if_done_out || bus.mem_done_out)) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", {30'd0, bus.mem_done_out, bus.if_done_out}, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk({e.tag, "_owner"}, {30'd0, bus.mem_done_out, bus.if_done_out},
            e.is_mem ? 32'd2 : 32'd1);
        chk({e.tag, "_cycle"}, cyc, e.cyc);
        if (e.chk_data)
          chk({e.tag, "_data"}, e.is_mem ? bus.mem_rdata_out : bus.if_data_out, e.data);
      end
    end
  end

  always @(negedge clk_in) begin
    if (rst_in && bus.ram_wr_out) begin
      if (wq.size() == 0) begin
        chk("write_unexpected", bus.ram_a_out, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("write_addr", bus.ram_a_out, w.addr);
        chk("write_data", {24'd0, bus.ram_dout_out}, {24'd0, w.data});
      end
    end
  end

  task automatic run_until_idle(input int max_cyc);
    logic md, id;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_in);
      md = bus.mem_done_out;
      id = bus.if_done_out;
      @(posedge clk_in); #1;
      if (md) bus.mem_req_in = 1'b0;
      if (id) bus.if_req_in  = 1'b0;
      if (!bus.mem_req_in && !bus.if_req_in) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
    bus.mem_req_in = 1'b0;
    bus.if_req_in  = 1'b0;
  endtask

  task automatic mem_xact(input vec_t v);
    int  t0;
    int  n;
    sb_t e;
    wr_t w;
    @(posedge clk_in); #1;
    bus.mem_we_in    = v.we;
    bus.mem_len_in   = v.len;
    bus.mem_addr_in  = v.addr;
    bus.mem_wdata_in = v.wdata;
    bus.mem_req_in   = 1'b1;
    t0 = cyc;
    n  = (v.len == 2'b00) ? 1 : (v.len == 2'b01) ? 2 : 4;
    if (v.we) begin
      for (int k = 0; k < n; k++) begin
        w.addr = v.addr + k;
        w.data = v.wdata[8*k +: 8];
        wq.push_back(w);
      end
    end
    e.is_mem = 1'b1; e.chk_data = !v.we; e.data = v.exp_rdata;
    e.cyc = t0 + 1 + v.lat; e.tag = v.tag;
    sb.push_back(e);
    run_until_idle(40);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ram_a"},   bus.ram_a_out, 32'd0);
    chk({tag, "_ram_wr"},  {31'd0, bus.ram_wr_out}, 32'd0);
    chk({tag, "_dout"},    {24'd0, bus.ram_dout_out}, 32'd0);
    chk({tag, "_busy"},    {31'd0, bus.busy_out}, 32'd0);
    chk({tag, "_dones"},   {30'd0, bus.mem_done_out, bus.if_done_out}, 32'd0);
    chk({tag, "_if_data"}, bus.if_data_out, 32'd0);
    chk({tag, "_rdata"},   bus.mem_rdata_out, 32'd0);
  endtask

  initial begin
    int  t0;
    sb_t e;
    wr_t w;

    vecs[0] = '{1'b1, 2'b01, 32'h0000_0100, 32'h0000_BEEF, 32'h0, 2, "st_half"};
    vecs[1] = '{1'b0, 2'b01, 32'h0000_0100, 32'h0, 32'h0000_BEEF, 3, "ld_half"};
    vecs[2] = '{1'b1, 2'b11, 32'h0000_0200, 32'h1122_3344, 32'h0, 4, "st_word"};
    vecs[3] = '{1'b0, 2'b11, 32'h0000_0200, 32'h0, 32'h1122_3344, 5, "ld_word"};
    vecs[4] = '{1'b1, 2'b00, 32'h0000_0203, 32'hFFFF_FFAA, 32'h0, 1, "st_byte"};
    vecs[5] = '{1'b0, 2'b10, 32'h0000_0200, 32'h0, 32'hAA22_3344, 5, "ld_len10"};
    vecs[6] = '{1'b0, 2'b00, 32'h0000_0203, 32'h0, 32'h0000_00AA, 2, "ld_byte_zx"};
    vecs[7] = '{1'b0, 2'b00, 32'h0000_0101, 32'h0, 32'h0000_00BE, 2, "ld_byte_hi"};
    vecs[8] = '{1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0, 32'h0302_015A, 5, "ld_wrap"};
    vecs[9] = '{1'b0, 2'b01, 32'h0000_1002, 32'h0, 32'h0000_1234, 3, "ld_half2"};

    rst_in = 1'b0;
    bus.rdy_in = 1'b1;
    bus.if_req_in = 1'b0;  bus.if_addr_in = '0;
    bus.mem_req_in = 1'b0; bus.mem_we_in = 1'b0; bus.mem_len_in = '0;
    bus.mem_addr_in = '0;  bus.mem_wdata_in = '0;
    bus.io_buffer_full_in = 1'b0;
    bus.ram_din_in = '0;

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk_reset_outputs("reset");
    @(posedge clk_in); #1;
    rst_in = 1'b1;

    // Word fetch: four consecutive byte addresses, done five cycles after grant.
    @(posedge clk_in); #1;
    bus.if_addr_in = 32'h0000_0004;
    bus.if_req_in  = 1'b1;
    t0 = cyc;
    e = '{1'b0, 1'b1, 32'h0000_0513, t0 + 6, "fetch"};
    sb.push_back(e);
    @(posedge clk_in);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk($sformatf("fetch_addr%0d", k), bus.ram_a_out, 32'h4 + k);
    end
    run_until_idle(20);

    // Simultaneous requests: MEM first, IF granted on the edge ending MEM's DONE.
    @(posedge clk_in); #1;
    bus.mem_we_in = 1'b0; bus.mem_len_in = 2'b11; bus.mem_addr_in = 32'h0000_1000;
    bus.if_addr_in = 32'h0000_0004;
    bus.mem_req_in = 1'b1;
    bus.if_req_in  = 1'b1;
    t0 = cyc;
    e = '{1'b1, 1'b1, 32'h1234_5678, t0 + 6, "prio_mem"};
    sb.push_back(e);
    e = '{1'b0, 1'b1, 32'h0000_0513, t0 + 12, "prio_if"};
    sb.push_back(e);
    run_until_idle(40);

    // UART store held off while the TX buffer is full.
    @(posedge clk_in); #1;
    bus.io_buffer_full_in = 1'b1;
    bus.mem_we_in = 1'b1; bus.mem_len_in = 2'b00;
    bus.mem_addr_in = IO_A; bus.mem_wdata_in = 32'h0000_0041;
    bus.mem_req_in = 1'b1;
    repeat (3) begin
      @(negedge clk_in);
      chk("io_blocked_busy", {31'd0, bus.busy_out}, 32'd0);
      chk("io_blocked_wr", {31'd0, bus.ram_wr_out}, 32'd0);
    end
    @(posedge clk_in); #1;
    bus.io_buffer_full_in = 1'b0;
    t0 = cyc;
    w.addr = IO_A; w.data = 8'h41;
    wq.push_back(w);
    e = '{1'b1, 1'b0, 32'h0, t0 + 2, "io_store"};
    sb.push_back(e);
    run_until_idle(20);

    for (int i = 0; i < 10; i++) mem_xact(vecs[i]);

    // Two stalled cycles after byte 1 of a word read.
    @(posedge clk_in); #1;
    bus.mem_we_in = 1'b0; bus.mem_len_in = 2'b11; bus.mem_addr_in = 32'h0000_1000;
    bus.mem_req_in = 1'b1;
    t0 = cyc;
    e = '{1'b1, 1'b1, 32'h1234_5678, t0 + 8, "stall_read"};
    sb.push_back(e);
    repeat (3) @(posedge clk_in);
    #1;
    bus.rdy_in = 1'b0;
    @(negedge clk_in);
    chk("stall_addr0", bus.ram_a_out, 32'h0000_1002);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    chk("stall_addr1", bus.ram_a_out, 32'h0000_1002);
    @(posedge clk_in); #1;
    bus.rdy_in = 1'b1;
    run_until_idle(20);

    // Reset in the middle of a word store: two bytes land, then everything clears.
    @(posedge clk_in); #1;
    bus.mem_we_in = 1'b1; bus.mem_len_in = 2'b11;
    bus.mem_addr_in = 32'h0000_0300; bus.mem_wdata_in = 32'hCAFE_F00D;
    bus.mem_req_in = 1'b1;
    w.addr = 32'h300; w.data = 8'h0D; wq.push_back(w);
    w.addr = 32'h301; w.data = 8'hF0; wq.push_back(w);
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    bus.mem_req_in = 1'b0;
    @(negedge clk_in);
    chk_reset_outputs("midrst");
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    mem_xact('{1'b0, 2'b01, 32'h0000_0300, 32'h0, 32'h0000_F00D, 3, "post_rst"});

    repeat (4) @(posedge clk_in);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    chk("wq_empty", wq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
